data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the pipeline's data-memory request interface. Receives
//  load/store requests from the EX/MEM stage, services them against an
//  internal word array after a fixed number of wait states, returns read
//  data and holds the pipeline via stall while busy.
//  Sits between the EX_MEM buffer outputs and the MEM_WB buffer inputs.
// PARAMETERS
//  DEPTH_WORDS  256  number of 32-bit words in the array (power of 2)
//  WAIT_STATES  2    extra cycles between accept and response (0..15)
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   synchronous, active-high reset
//  req_valid   in   1   request present; held stable by initiator while stall=1
//  req_write   in   1   1 = store, 0 = load
//  req_addr    in   32  byte address (ALU result)
//  req_wdata   in   32  store data
//  req_ready   out  1   responder can accept a request this cycle
//  resp_valid  out  1   one-cycle pulse: response valid
//  resp_rdata  out  32  load data (0 for stores and errors)
//  resp_err    out  1   qualified by resp_valid: misaligned or out-of-range
//  stall       out  1   pipeline must hold all stage registers
// BEHAVIOUR
//  - Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0,
//    stall=0, wait counter=0. Array contents not cleared by rst.
//  - FSM IDLE/WAIT/RESP:
//    IDLE: req_ready=1. req_valid=1 -> capture write, addr, wdata; go WAIT
//      (or RESP if WAIT_STATES=0); counter loaded with WAIT_STATES-1.
//    WAIT: counter decrements each cycle; at 0 -> RESP.
//    RESP: resp_valid=1 for exactly one cycle; -> IDLE unconditionally.
//  - Latency: accept at cycle T -> resp_valid at T+WAIT_STATES+1.
//  - req_ready=1 only in IDLE; requests in WAIT/RESP are ignored.
//  - stall = (state==IDLE & req_valid) | (state==WAIT); stall=0 in RESP so
//    the pipeline advances on the response edge. Back-to-back requests are
//    accepted in the IDLE cycle following RESP.
//  - Addressing: word index = addr[log2(DEPTH_WORDS)+1:2].
//    err if addr[1:0]!=0 or any addr bit above the index field is 1.
//  - Store: array written on the clock edge entering RESP, only if !err.
//    resp_rdata=0 for stores.
//  - Load: resp_rdata = array[index] sampled on the edge entering RESP,
//    or 0 if err. resp_rdata/resp_err held until next response; valid only
//    with resp_valid.
//  - Load after store to the same word returns the new data (write is
//    committed before the later request is accepted).
//  - rst during WAIT or RESP: return to IDLE, no response issued, pending
//    store discarded (array unchanged).
// STRUCTURE
//  - Shared package: state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2),
//    WORD_W=32, alignment mask 2'b00.
//  - Sub-module dmem_array: single-port synchronous word RAM
//    (clk, we, idx, wdata, rdata), instantiated once; the FSM, counter and
//    error check live in the top.
// TESTING
//  - rst held 2 cycles -> req_ready=1, stall=0, resp_valid=0, resp_rdata=0.
//  - store 0xDEADBEEF @0x10, WAIT_STATES=2 -> stall high 3 cycles,
//    resp_valid at T+3 with err=0; then load @0x10 -> rdata=0xDEADBEEF.
//  - load @0x13 (misaligned) -> resp_err=1, rdata=0; store @0x400 with
//    DEPTH=256 -> err=1, and a later load @0x0 returns unchanged contents.
//  - back-to-back: store @0x8=5 then immediately load @0x8 -> second accept
//    one cycle after first resp_valid; rdata=5.
//  - rst asserted in WAIT of store 0x1234 @0x20 -> no resp_valid;
//    subsequent load @0x20 returns the prior value.
//  - WAIT_STATES=0 build: load accepted at T -> resp_valid at T+1,
//    stall high exactly 1 cycle.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_responder_pkg
//   Shared definitions for the data-memory responder: the FSM state encoding,
//   the data word width, the required byte-offset value for an aligned word
//   access, and the address error check used by the top.
// -----------------------------------------------------------------------------
package data_mem_responder_pkg;

  localparam int WORD_W = 32;

  // A word access is aligned when the two byte-offset bits equal this value.
  localparam logic [1:0] ALIGN_MASK = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // An address is in error when it is not word aligned or when any bit above
  // the word-index field is set (hi_mask selects exactly those bits).
  function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                    input logic [WORD_W-1:0] hi_mask);
    return (addr[1:0] != ALIGN_MASK) || ((addr & hi_mask) != '0);
  endfunction

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
//   Single-port synchronous word RAM. The write and the read of the addressed
//   word both happen on the rising edge; a read of the word being written
//   returns the old contents.
// Ports
//   clk    in   1       rising-edge clock
//   we     in   1       write enable
//   idx    in   IDX_W   word index
//   wdata  in   WORD_W  write data
//   rdata  out  WORD_W  registered read data of mem[idx]
// -----------------------------------------------------------------------------
module dmem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // NOTE: the array has no reset; clearing it would force a flop-based
  // implementation instead of a RAM, and its contents must survive rst.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Responder end of the pipeline's data-memory request interface. Accepts a
//   load or store in IDLE, waits WAIT_STATES cycles, then issues a one-cycle
//   response. The pipeline is held via stall from the accept cycle until the
//   response cycle, in which it is released so it advances on the response.
// Ports
//   clk         in   1   rising-edge clock
//   rst         in   1   synchronous active-high reset
//   req_valid   in   1   request present (held stable while stall=1)
//   req_write   in   1   1 = store, 0 = load
//   req_addr    in   32  byte address
//   req_wdata   in   32  store data
//   req_ready   out  1   request can be accepted this cycle (IDLE only)
//   resp_valid  out  1   one-cycle response pulse
//   resp_rdata  out  32  load data, 0 for stores and errors; held until the
//                        next response
//   resp_err    out  1   misaligned or out-of-range address; held likewise
//   stall       out  1   pipeline must hold its stage registers
// -----------------------------------------------------------------------------
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              stall
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  // Address bits above the word-index field; any of them set is an error.
  localparam logic [WORD_W-1:0] HI_MASK =
    ~((WORD_W'(1) << (IDX_W + 2)) - WORD_W'(1));

  localparam bit       ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0] CNT_INIT = ZERO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t            state, state_next;
  logic [3:0]        cnt, cnt_next;

  // Request captured at accept.
  logic              cap_write;
  logic              cap_err;
  logic [IDX_W-1:0]  cap_idx;
  logic [WORD_W-1:0] cap_wdata;

  // Last response, presented between responses.
  logic [WORD_W-1:0] hold_rdata;
  logic              hold_err;

  logic              accept;
  logic              req_err;
  logic [IDX_W-1:0]  req_idx;

  // Access currently being serviced: straight from the request port in IDLE
  // (needed when WAIT_STATES=0 enters RESP on the accept edge), otherwise
  // from the capture registers.
  logic              cur_write;
  logic              cur_err;
  logic [IDX_W-1:0]  cur_idx;
  logic [WORD_W-1:0] cur_wdata;

  logic              enter_resp;
  logic              ram_we;
  logic [WORD_W-1:0] ram_rdata;
  logic [WORD_W-1:0] resp_now;

  assign accept  = (state == IDLE) && req_valid;
  assign req_err = addr_err(req_addr, HI_MASK);
  assign req_idx = req_addr[IDX_W+1:2];

  assign cur_write = (state == IDLE) ? req_write : cap_write;
  assign cur_err   = (state == IDLE) ? req_err   : cap_err;
  assign cur_idx   = (state == IDLE) ? req_idx   : cap_idx;
  assign cur_wdata = (state == IDLE) ? req_wdata : cap_wdata;

  // The store commits on the edge entering RESP; a reset on that same edge
  // discards it.
  assign enter_resp = (state_next == RESP);
  assign ram_we     = enter_resp && cur_write && !cur_err && !rst;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .idx   (cur_idx),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  // NOTE: every signal driven here gets a default first so no path through
  // the case statement leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (ZERO_WAIT) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Response value for the access just completed: the RAM output holds the
  // word read on the edge entering RESP.
  assign resp_now = (cap_write || cap_err) ? '0 : ram_rdata;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign stall      = accept || (state == WAIT);
  assign resp_rdata = resp_valid ? resp_now : hold_rdata;
  assign resp_err   = resp_valid ? cap_err  : hold_err;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      cap_write  <= 1'b0;
      cap_err    <= 1'b0;
      cap_idx    <= '0;
      cap_wdata  <= '0;
      hold_rdata <= '0;
      hold_err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        cap_write <= req_write;
        cap_err   <= req_err;
        cap_idx   <= req_idx;
        cap_wdata <= req_wdata;
      end
      if (state == RESP) begin
        hold_rdata <= resp_now;
        hold_err   <= cap_err;
      end
    end
  end

endmodule
